// File: rtl/bist_fail_logger.sv
// bist_fail_logger
// Collects the compare stream of the SRAM March-test BIST. The first DEPTH
// failing reads of a run go into a small FIFO as {addr, exp, act, pattern}
// records. Alongside the FIFO the block keeps a saturating fail count, a
// sticky OR of failing bit columns and a sticky overflow flag.
module bist_fail_logger #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       cmp_valid,
  input  logic [ADDR_W-1:0]          cmp_addr,
  input  logic [DATA_W-1:0]          cmp_exp,
  input  logic [DATA_W-1:0]          cmp_act,
  input  logic [2:0]                 cmp_pattern,
  input  logic                       bist_done_in,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_exp,
  output logic [DATA_W-1:0]          rd_act,
  output logic [2:0]                 rd_pattern,
  output logic [$clog2(DEPTH):0]     log_count,
  output logic [CNT_W-1:0]           fail_count,
  output logic [DATA_W-1:0]          fail_bits,
  output logic                       overflow,
  output logic                       busy,
  output logic                       summary_valid,
  output logic                       pass
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LOG_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_done_prev;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [LOG_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_fail_count;
  logic [DATA_W-1:0]   r_fail_bits;
  logic                r_overflow;

  logic [ADDR_W-1:0]   r_mem_addr [DEPTH];
  logic [DATA_W-1:0]   r_mem_exp  [DEPTH];
  logic [DATA_W-1:0]   r_mem_act  [DEPTH];
  logic [2:0]          r_mem_pat  [DEPTH];

  logic                w_done_edge;
  logic                w_fail;
  logic                w_rd_valid;
  logic                w_pop;
  logic                w_full;
  logic                w_push;
  logic                w_restart;
  logic                w_flush;

  // start only re-arms the logger outside COLLECT; clear or a re-arm wipes
  // all run state. A pop in a flush cycle is irrelevant since the FIFO empties.
  assign w_done_edge = bist_done_in & ~r_done_prev;
  assign w_fail      = (r_state == ST_COLLECT) & cmp_valid & (cmp_exp != cmp_act);
  assign w_rd_valid  = (r_count != {LOG_W{1'b0}});
  assign w_pop       = w_rd_valid & rd_ready;
  assign w_full      = (r_count == LOG_W'(DEPTH));
  assign w_push      = w_fail & (~w_full | w_pop);
  assign w_restart   = start & (r_state != ST_COLLECT);
  assign w_flush     = clear | w_restart;

  // Next-state decode: clear beats start, start beats the done edge.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    w_state_nxt = start       ? ST_COLLECT : ST_IDLE;
        ST_COLLECT: w_state_nxt = w_done_edge ? ST_DONE    : ST_COLLECT;
        ST_DONE:    w_state_nxt = start       ? ST_COLLECT : ST_DONE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Previous bist_done_in level for rising-edge detection; restarts at 0 on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_prev <= 1'b0;
    end else begin
      r_done_prev <= bist_done_in;
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle net to no change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {LOG_W{1'b0}};
    end else if (w_flush) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {LOG_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + LOG_W'(w_push) - LOG_W'(w_pop);
    end
  end

  // Record storage; contents are only visible through the rd_valid-gated head.
  always_ff @(posedge clk) begin
    if (w_push && !w_flush) begin
      r_mem_addr[r_wr_ptr] <= cmp_addr;
      r_mem_exp[r_wr_ptr]  <= cmp_exp;
      r_mem_act[r_wr_ptr]  <= cmp_act;
      r_mem_pat[r_wr_ptr]  <= cmp_pattern;
    end
  end

  // Run statistics: every fail is counted, dropped ones also raise overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail_count <= {CNT_W{1'b0}};
      r_fail_bits  <= {DATA_W{1'b0}};
      r_overflow   <= 1'b0;
    end else if (w_flush) begin
      r_fail_count <= {CNT_W{1'b0}};
      r_fail_bits  <= {DATA_W{1'b0}};
      r_overflow   <= 1'b0;
    end else if (w_fail) begin
      if (r_fail_count != {CNT_W{1'b1}}) begin
        r_fail_count <= r_fail_count + CNT_W'(1);
      end
      r_fail_bits <= r_fail_bits | (cmp_exp ^ cmp_act);
      if (!w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Head fields read as zero whenever the FIFO is empty, including after reset.
  assign rd_valid      = w_rd_valid;
  assign rd_addr       = w_rd_valid ? r_mem_addr[r_rd_ptr] : {ADDR_W{1'b0}};
  assign rd_exp        = w_rd_valid ? r_mem_exp[r_rd_ptr]  : {DATA_W{1'b0}};
  assign rd_act        = w_rd_valid ? r_mem_act[r_rd_ptr]  : {DATA_W{1'b0}};
  assign rd_pattern    = w_rd_valid ? r_mem_pat[r_rd_ptr]  : 3'd0;
  assign log_count     = r_count;
  assign fail_count    = r_fail_count;
  assign fail_bits     = r_fail_bits;
  assign overflow      = r_overflow;
  assign busy          = (r_state == ST_COLLECT);
  assign summary_valid = (r_state == ST_DONE);
  assign pass          = (r_state == ST_DONE) && (r_fail_count == {CNT_W{1'b0}});

endmodule

// File: tb/tb_bist_fail_logger.sv
// Directed bench for bist_fail_logger: inputs change 1 ns after a rising
// edge, outputs are checked 1 ns after the following rising edge.
module tb_bist_fail_logger;

  logic        clk;
  logic        rst;
  logic        start;
  logic        clear;
  logic        cmp_valid;
  logic [12:0] cmp_addr;
  logic [31:0] cmp_exp;
  logic [31:0] cmp_act;
  logic [2:0]  cmp_pattern;
  logic        bist_done_in;
  logic        rd_valid;
  logic        rd_ready;
  logic [12:0] rd_addr;
  logic [31:0] rd_exp;
  logic [31:0] rd_act;
  logic [2:0]  rd_pattern;
  logic [3:0]  log_count;
  logic [15:0] fail_count;
  logic [31:0] fail_bits;
  logic        overflow;
  logic        busy;
  logic        summary_valid;
  logic        pass;

  int total;
  int bad;

  bist_fail_logger dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .cmp_valid(cmp_valid), .cmp_addr(cmp_addr), .cmp_exp(cmp_exp),
    .cmp_act(cmp_act), .cmp_pattern(cmp_pattern), .bist_done_in(bist_done_in),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_exp(rd_exp), .rd_act(rd_act), .rd_pattern(rd_pattern),
    .log_count(log_count), .fail_count(fail_count), .fail_bits(fail_bits),
    .overflow(overflow), .busy(busy), .summary_valid(summary_valid), .pass(pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %0h want 0", rd_valid); end
    total++; if (log_count !== 4'd0) begin bad++; $display("FAIL reset_log_count: got %0d want 0", log_count); end
    total++; if (fail_count !== 16'd0) begin bad++; $display("FAIL reset_fail_count: got %0d want 0", fail_count); end
    total++; if (fail_bits !== 32'd0) begin bad++; $display("FAIL reset_fail_bits: got %0h want 0", fail_bits); end
    total++; if ({overflow, busy, summary_valid, pass} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {overflow, busy, summary_valid, pass}); end
    total++; if ({rd_addr, rd_exp, rd_act, rd_pattern} !== 80'd0) begin bad++; $display("FAIL reset_rd_fields: got %0h want 0", {rd_addr, rd_exp, rd_act, rd_pattern}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_pass_run();
    do_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL pass_busy: got %0h want 1", busy); end
    for (int i = 0; i < 5; i++) begin
      cmp_valid = 1'b1; cmp_addr = 13'(i); cmp_exp = 32'h55555555; cmp_act = 32'h55555555; cmp_pattern = 3'd0;
      tick();
    end
    cmp_valid = 1'b0;
    bist_done_in = 1'b1;
    tick();
    total++; if (summary_valid !== 1'b1) begin bad++; $display("FAIL pass_summary_valid: got %0h want 1", summary_valid); end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL pass_pass: got %0h want 1", pass); end
    total++; if (fail_count !== 16'd0) begin bad++; $display("FAIL pass_fail_count: got %0d want 0", fail_count); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL pass_rd_valid: got %0h want 0", rd_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL pass_busy_done: got %0h want 0", busy); end
    bist_done_in = 1'b0;
  endtask

  task automatic test_single_fail();
    do_start();
    cmp_valid = 1'b1; cmp_addr = 13'h0A3; cmp_exp = 32'hFFFFFFFF; cmp_act = 32'hFFFF7FFF; cmp_pattern = 3'd1;
    tick();
    cmp_valid = 1'b0;
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL single_rd_valid: got %0h want 1", rd_valid); end
    total++; if (rd_addr !== 13'h0A3) begin bad++; $display("FAIL single_rd_addr: got %0h want a3", rd_addr); end
    total++; if (rd_exp !== 32'hFFFFFFFF) begin bad++; $display("FAIL single_rd_exp: got %0h want ffffffff", rd_exp); end
    total++; if (rd_act !== 32'hFFFF7FFF) begin bad++; $display("FAIL single_rd_act: got %0h want ffff7fff", rd_act); end
    total++; if (rd_pattern !== 3'd1) begin bad++; $display("FAIL single_rd_pattern: got %0d want 1", rd_pattern); end
    total++; if (fail_bits !== 32'h00008000) begin bad++; $display("FAIL single_fail_bits: got %0h want 8000", fail_bits); end
    total++; if (fail_count !== 16'd1) begin bad++; $display("FAIL single_fail_count: got %0d want 1", fail_count); end
    repeat (3) tick();
    total++; if ({rd_valid, rd_addr, rd_act} !== {1'b1, 13'h0A3, 32'hFFFF7FFF}) begin bad++; $display("FAIL single_hold: got %0h want %0h", {rd_valid, rd_addr, rd_act}, {1'b1, 13'h0A3, 32'hFFFF7FFF}); end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL single_pop_rd_valid: got %0h want 0", rd_valid); end
    total++; if (log_count !== 4'd0) begin bad++; $display("FAIL single_pop_log_count: got %0d want 0", log_count); end
  endtask

  task automatic test_overflow();
    do_clear();
    do_start();
    for (int i = 0; i < 10; i++) begin
      cmp_valid = 1'b1; cmp_addr = 13'h100 + 13'(i); cmp_exp = 32'h0; cmp_act = 32'(i + 1); cmp_pattern = 3'(i);
      tick();
    end
    cmp_valid = 1'b0;
    total++; if (log_count !== 4'd8) begin bad++; $display("FAIL ovf_log_count: got %0d want 8", log_count); end
    total++; if (fail_count !== 16'd10) begin bad++; $display("FAIL ovf_fail_count: got %0d want 10", fail_count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_overflow: got %0h want 1", overflow); end
    total++; if (fail_bits !== 32'h0000000F) begin bad++; $display("FAIL ovf_fail_bits: got %0h want f", fail_bits); end
    for (int i = 0; i < 8; i++) begin
      total++; if ({rd_valid, rd_addr, rd_act} !== {1'b1, 13'h100 + 13'(i), 32'(i + 1)}) begin bad++; $display("FAIL ovf_drain_%0d: got %0h want %0h", i, {rd_valid, rd_addr, rd_act}, {1'b1, 13'h100 + 13'(i), 32'(i + 1)}); end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %0h want 0", rd_valid); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    do_start();
    for (int i = 0; i < 8; i++) begin
      cmp_valid = 1'b1; cmp_addr = 13'h200 + 13'(i); cmp_exp = 32'h0; cmp_act = 32'h1 << i; cmp_pattern = 3'd2;
      tick();
    end
    total++; if ({log_count, overflow} !== {4'd8, 1'b0}) begin bad++; $display("FAIL b2b_full: got %0h want 10", {log_count, overflow}); end
    cmp_addr = 13'h208; cmp_act = 32'h100;
    rd_ready = 1'b1;
    tick();
    cmp_valid = 1'b0;
    rd_ready = 1'b0;
    total++; if (log_count !== 4'd8) begin bad++; $display("FAIL b2b_log_count: got %0d want 8", log_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow: got %0h want 0", overflow); end
    total++; if (fail_count !== 16'd9) begin bad++; $display("FAIL b2b_fail_count: got %0d want 9", fail_count); end
    for (int i = 0; i < 8; i++) begin
      total++; if ({rd_valid, rd_addr} !== {1'b1, 13'h201 + 13'(i)}) begin bad++; $display("FAIL b2b_drain_%0d: got %0h want %0h", i, {rd_valid, rd_addr}, {1'b1, 13'h201 + 13'(i)}); end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    total++; if (log_count !== 4'd0) begin bad++; $display("FAIL b2b_empty: got %0d want 0", log_count); end
  endtask

  task automatic test_done_edge_fail();
    do_clear();
    do_start();
    cmp_valid = 1'b1; cmp_addr = 13'h055; cmp_exp = 32'hA5A5A5A5; cmp_act = 32'hA5A5A5A4; cmp_pattern = 3'd3;
    bist_done_in = 1'b1;
    tick();
    total++; if ({summary_valid, pass} !== 2'b10) begin bad++; $display("FAIL edge_summary: got %b want 10", {summary_valid, pass}); end
    total++; if (fail_count !== 16'd1) begin bad++; $display("FAIL edge_fail_count: got %0d want 1", fail_count); end
    total++; if ({log_count, rd_addr} !== {4'd1, 13'h055}) begin bad++; $display("FAIL edge_logged: got %0h want %0h", {log_count, rd_addr}, {4'd1, 13'h055}); end
    cmp_addr = 13'h077;
    tick();
    cmp_valid = 1'b0;
    total++; if ({fail_count, log_count} !== {16'd1, 4'd1}) begin bad++; $display("FAIL edge_done_ignored: got %0h want %0h", {fail_count, log_count}, {16'd1, 4'd1}); end
    bist_done_in = 1'b0;
    do_clear();
    total++; if ({busy, summary_valid, rd_valid, overflow} !== 4'b0000) begin bad++; $display("FAIL clear_flags: got %b want 0000", {busy, summary_valid, rd_valid, overflow}); end
    total++; if ({fail_count, fail_bits, log_count} !== 52'd0) begin bad++; $display("FAIL clear_counts: got %0h want 0", {fail_count, fail_bits, log_count}); end
    do_start();
    cmp_valid = 1'b1; cmp_exp = 32'h12345678; cmp_act = 32'h12345678;
    tick();
    cmp_valid = 1'b0;
    bist_done_in = 1'b1;
    tick();
    total++; if ({summary_valid, pass} !== 2'b11) begin bad++; $display("FAIL clean_rerun: got %b want 11", {summary_valid, pass}); end
    bist_done_in = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid_run();
    do_start();
    for (int i = 0; i < 3; i++) begin
      cmp_valid = 1'b1; cmp_addr = 13'h300 + 13'(i); cmp_exp = 32'hFFFFFFFF; cmp_act = 32'h0; cmp_pattern = 3'd4;
      tick();
    end
    cmp_valid = 1'b0;
    total++; if ({busy, log_count} !== {1'b1, 4'd3}) begin bad++; $display("FAIL rst_pre: got %0h want 13", {busy, log_count}); end
    #2;
    rst = 1'b1;
    #1;
    total++; if ({rd_valid, log_count, overflow, busy, summary_valid, pass} !== 9'd0) begin bad++; $display("FAIL rst_async_flags: got %0h want 0", {rd_valid, log_count, overflow, busy, summary_valid, pass}); end
    total++; if ({fail_count, fail_bits} !== 48'd0) begin bad++; $display("FAIL rst_async_counts: got %0h want 0", {fail_count, fail_bits}); end
    total++; if ({rd_addr, rd_exp, rd_act, rd_pattern} !== 80'd0) begin bad++; $display("FAIL rst_async_fields: got %0h want 0", {rd_addr, rd_exp, rd_act, rd_pattern}); end
    tick();
    rst = 1'b0;
    tick();
    total++; if ({busy, rd_valid} !== 2'b00) begin bad++; $display("FAIL rst_after: got %b want 00", {busy, rd_valid}); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    cmp_valid = 1'b0;
    cmp_addr = 13'd0;
    cmp_exp = 32'd0;
    cmp_act = 32'd0;
    cmp_pattern = 3'd0;
    bist_done_in = 1'b0;
    rd_ready = 1'b0;
    test_reset();
    test_pass_run();
    test_single_fail();
    test_overflow();
    test_back_to_back();
    test_done_edge_fail();
    test_rst_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bist_fail_logger.md
# bist_fail_logger

Downstream companion to the SRAM March-test BIST controller. It consumes the per-read compare stream (address, expected and actual word, pattern index) and the done flag, and records the first DEPTH failing reads in a small FIFO. It also keeps a saturating fail count and a sticky per-bit fail mask, so diagnosis software or a scan-out stage can tell which addresses and bit columns failed, and under which pattern.

## Interface
- ADDR_W, 13, memory address width (8K words)
- DATA_W, 32, memory data width
- DEPTH, 8, fail-record FIFO entries (power of two, ≥2)
- CNT_W, 16, fail counter width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begin a new collection run
- clear  in  1  pulse; abort and return to IDLE
- cmp_valid  in  1  compare sample valid this cycle
- cmp_addr  in  ADDR_W  address of the read
- cmp_exp  in  DATA_W  expected word (pattern_0 or pattern_1)
- cmp_act  in  DATA_W  word read from memory
- cmp_pattern  in  3  pattern index active during the read
- bist_done_in  in  1  level from the BIST controller; run finished
- rd_valid  out  1  FIFO head record available
- rd_ready  in  1  consumer accepts head record
- rd_addr / rd_exp / rd_act / rd_pattern  out  ADDR_W/DATA_W/DATA_W/3  head record fields
- log_count  out  log2(DEPTH)+1  records currently held
- fail_count  out  CNT_W  total fails this run, saturating
- fail_bits  out  DATA_W  OR of (exp ^ act) over all fails this run
- overflow  out  1  sticky; a fail was dropped because the FIFO was full
- busy  out  1  state == COLLECT
- summary_valid  out  1  state == DONE
- pass  out  1  summary_valid and fail_count == 0

## Operation
- States: IDLE, COLLECT, DONE.
- IDLE → COLLECT on start. Entry zeroes fail_count, fail_bits and overflow, and empties the FIFO.
- COLLECT → DONE on the rising edge of bist_done_in (0 in previous cycle, 1 now).
- DONE → COLLECT on start; any state → IDLE on clear.
- clear has priority over start, which has priority over the done edge and cmp_valid. clear also empties the FIFO and zeroes all counters and flags.
- start while in COLLECT is ignored.
- A fail is a cycle in COLLECT with cmp_valid = 1 and cmp_exp ≠ cmp_act. Each fail:
  - fail_count increments and saturates at 2^CNT_W−1.
  - fail_bits |= cmp_exp ^ cmp_act.
  - If the FIFO has room, or is full but a pop happens in the same cycle, the record {addr, exp, act, pattern} is pushed; otherwise overflow sets.
- cmp_valid in IDLE or DONE is ignored.
- A fail in the same cycle as the done edge is still counted and logged.
- Pop occurs when rd_valid & rd_ready, in any state; the FIFO can be drained during a run.
- Records leave in arrival order. Dropped fails are never logged, but they are counted.
- Head record fields hold stable while rd_valid = 1 and rd_ready = 0.

## Timing
- Reset values: state IDLE; rd_valid 0; all rd_* fields 0; log_count 0; fail_count 0; fail_bits 0; overflow 0; busy 0; summary_valid 0; pass 0.
- Fail sampled at edge N:
  - fail_count, fail_bits and overflow update at edge N.
  - With an empty FIFO, rd_valid = 1 with that record from edge N (one-cycle latency from the cmp_valid cycle).
- Pop at edge N: the next record, or rd_valid = 0, is shown from edge N. log_count reflects both push and pop of the same cycle (net 0 change).
- busy rises one cycle after the start cycle. summary_valid rises one cycle after the done-edge cycle.
- rst mid-run: the FIFO is discarded immediately; bist_done_in edge detection restarts with previous value 0.

## Test plan
- Reset, then start with 5 compare samples, all exp = act = 0x55555555, then done edge → summary_valid = 1, pass = 1, fail_count = 0, rd_valid = 0.
- Start, then one fail (addr 0x0A3, exp 0xFFFFFFFF, act 0xFFFF7FFF, pattern 1), rd_ready = 0 → rd_valid next cycle. Head = {0x0A3, 0xFFFFFFFF, 0xFFFF7FFF, 1}, fail_bits = 0x00008000, fail_count = 1, and the head holds stable.
- 10 fails back-to-back with rd_ready = 0 and DEPTH = 8 → log_count = 8, fail_count = 10, overflow = 1. Draining yields the first 8 addresses in order.
- FIFO full with rd_ready = 1 while a new fail arrives → pop and push in the same edge; log_count stays 8 and overflow stays 0.
- Fail in the same cycle as the bist_done_in rise → fail counted, then summary_valid = 1 and pass = 0. Then clear → IDLE with all counters 0. A subsequent start with clean data → pass = 1.
- Assert rst mid-COLLECT with 3 records held → all outputs return to reset values asynchronously.
